rt_fetch_prefetch: RTL

RT-Core instruction prefetch unit, sitting directly upstream of the RT-Core 2KB instruction cache and directly downstream of nothing but the PC/redirect logic. It issues sequential word fetches to the I-cache using that cache's request/ready protocol. It buffers returned instructions in a small FIFO and presents them to the RT decode stage over a valid/ready handshake. Branch redirects flush the buffer, and a watchdog converts a stalled cache (error state) into a sticky fault.

---
 rtl/rt_fetch_prefetch.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rt_fetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : rt_fetch_prefetch
// Purpose  : RT-Core sequential instruction prefetcher with redirect flush,
//            decode-side FIFO and I-cache stall watchdog.
// Revision : 1.0
// ============================================================================
module rt_fetch_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          TIMEOUT  = 128
) (
  input  logic                     clk_rt_50mhz,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [15:0]              redirect_pc,
  output logic                     ic_req,
  output logic [15:0]              ic_addr,
  input  logic [15:0]              ic_data,
  input  logic                     ic_ready,
  input  logic                     ic_idle,
  output logic                     dec_valid,
  output logic [15:0]              dec_instr,
  output logic [15:0]              dec_pc,
  input  logic                     dec_ready,
  output logic                     fetch_fault,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] c_depth    = LW'(DEPTH);
  localparam logic [7:0]    c_tmo_last = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_REQ   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t        r_state,    w_state_nxt;
  logic [15:0]   r_fetch_pc, w_fetch_pc_nxt;
  logic [15:0]   r_pend_pc,  w_pend_pc_nxt;
  logic          r_discard,  w_discard_nxt;
  logic [7:0]    r_tcnt,     w_tcnt_nxt;
  logic          r_fault,    w_fault_nxt;
  logic          w_push;
  logic          w_pop;

  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  always_ff @(posedge clk_rt_50mhz) begin
    if (rst) begin
      r_state    <= S_WAIT;
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= '0;
      r_discard  <= 1'b0;
      r_tcnt     <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
      r_discard  <= w_discard_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_pend_pc_nxt  = r_pend_pc;
    w_discard_nxt  = r_discard;
    w_tcnt_nxt     = r_tcnt;
    w_fault_nxt    = r_fault;
    w_push         = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (redirect_valid) begin
          w_fetch_pc_nxt = redirect_pc;
        end else if (ic_idle && (r_level < c_depth)) begin
          w_state_nxt = S_REQ;
          w_tcnt_nxt  = '0;
        end
      end
      S_REQ: begin
        if (ic_ready) begin
          w_state_nxt   = S_WAIT;
          w_discard_nxt = 1'b0;
          if (redirect_valid) begin
            w_fetch_pc_nxt = redirect_pc;
          end else if (r_discard) begin
            w_fetch_pc_nxt = r_pend_pc;
          end else begin
            w_push         = 1'b1;
            w_fetch_pc_nxt = r_fetch_pc + 16'd1;
          end
        end else begin
          // The cache fills from the live address, so a redirect here is
          // parked until the outstanding word returns.
          if (redirect_valid) begin
            w_pend_pc_nxt = redirect_pc;
            w_discard_nxt = 1'b1;
          end
          if (r_tcnt == c_tmo_last) begin
            w_state_nxt   = S_FAULT;
            w_fault_nxt   = 1'b1;
            w_tcnt_nxt    = '0;
            w_discard_nxt = 1'b0;
          end else begin
            w_tcnt_nxt = r_tcnt + 8'd1;
          end
        end
      end
      S_FAULT: begin
        if (redirect_valid) begin
          w_state_nxt    = S_WAIT;
          w_fault_nxt    = 1'b0;
          w_fetch_pc_nxt = redirect_pc;
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // A redirect flushes the buffer and overrides any pop in the same cycle.
  assign w_pop = dec_valid && dec_ready && !redirect_valid;

  always_ff @(posedge clk_rt_50mhz) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {r_fetch_pc, ic_data};
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign ic_req      = (r_state == S_REQ);
  assign ic_addr     = r_fetch_pc;
  assign dec_valid   = (r_level != '0);
  assign dec_pc      = r_mem[r_rd_ptr][31:16];
  assign dec_instr   = r_mem[r_rd_ptr][15:0];
  assign fetch_fault = r_fault;
  assign fifo_level  = r_level;

endmodule
`default_nettype wire
